seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Time-multiplexed 4-digit seven-segment display driver: the display-side consumer of the clock core's digit outputs (H1, H2, M1, M2). Captures a coherent HH:MM snapshot once per frame, decodes each digit to segments, scans the common-anode digits with inter-digit blanking, and blinks the hour or minute field while it is being adjusted. Sits between the clock and alarm time sources and the board pins.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- SCAN_HZ, 1000: digit-advance rate. DIV = CLK_HZ/SCAN_HZ, integer and ≥ 4.
- BLINK_HZ, 2: blink rate. HALF = CLK_HZ/(2*BLINK_HZ), integer.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- H1  in  2  hours tens digit.
- H2  in  4  hours units digit.
- M1  in  3  minutes tens digit.
- M2  in  4  minutes units digit.
- blink_sel  in  2  00 none, 01 minutes, 10 hours, 11 both.
- dp_en  in  1  enables the colon decimal point.
- an  out  4  digit enables, active-low; an[0] = M2 … an[3] = H1.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse when a new snapshot is captured.

## Operation
- Prescaler pcnt counts 0..DIV-1 and wraps. tick = (pcnt == DIV-1).
- Digit index idx is 2 bits and holds the currently displayed digit. On tick, idx increments mod 4. Digit map: 0 = M2, 1 = M1, 2 = H2, 3 = H1.
- Snapshot: on a tick where idx goes 3→0, latch {H1,H2,M1,M2} into the snapshot register and pulse frame. Inputs are never read at any other time, so there is no tearing.
- Blink counter counts 0..HALF-1. At wrap, blink_phase toggles.
- Blanked digit: blink_phase = 1 and the digit is in a selected field (idx 0,1 for minutes; idx 2,3 for hours). A blanked digit drives an = 1111 for its whole slot.
- Decode (snapshot value zero-extended to 4 bits):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10–15 show a dash, 0111111.
- dp = 0 only when idx = 2, dp_en = 1 and blink_phase = 0. Otherwise dp = 1. dp is independent of blink_sel.

## Timing
- All outputs are registered.
- Reset values: an = 1111, seg = 1111111, dp = 1, frame = 0, pcnt = 0, idx = 3, blink counter = 0, blink_phase = 0, snapshot = 0.
- Cycle T = tick edge. At T:
  - idx and snapshot (if applicable) update.
  - an is forced to 1111 for one cycle (anti-ghost gap).
  - seg and dp load the new digit's values.
  - frame asserts at T for exactly one cycle on a 3→0 advance.
- At T+1, an drives the new digit (one-hot low) unless the digit is blanked. an stays there until the next tick.
- First frame after reset release: DIV edges to the first tick. Digit 0 is shown from edge DIV+1.
- Latency from input change to display: captured at the next 3→0 tick. Worst case is 4*DIV cycles, plus 1 cycle to appear on an.
- blink_sel and dp_en are sampled every cycle. Their effect appears on the next registered update.
- blink_phase toggling mid-slot takes effect on an on the next edge.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronously). Scan restarts from the reset state on release.

## Configuration
- LEADING_ZERO_BLANK_EN defined: when the snapshot H1 = 0, digit 3 drives an = 1111 for its slot, so 09:05 displays as " 9:05".
- LEADING_ZERO_BLANK_EN undefined: H1 = 0 is shown as "0" like any other digit.
- Neither setting affects timing, dp, or the other digits.

## Test plan
Bench parameters: CLK_HZ = 1000, SCAN_HZ = 100 (DIV = 10), BLINK_HZ = 5 (HALF = 100).
- Reset: hold rst = 0 with inputs 12:34 → an = 1111, seg = 1111111, dp = 1. Release → an = 1111 for edges 1–10. Edge 10 gives frame = 1 and seg = 0011001. Edge 11 gives an = 1110.
- Scan of 12:34, dp_en = 1, blink_sel = 00 → slot sequence:
  - an 1110 / seg 0011001
  - an 1101 / seg 0110000
  - an 1011 / seg 0100100 / dp = 0 (only while blink_phase = 0)
  - an 0111 / seg 1111001
  - A one-cycle an = 1111 gap occurs at every tick.
- Snapshot coherence: change inputs to 23:59 during the idx = 1 slot → the display shows 12:34 until the next frame pulse, then 23:59 on all four digits.
- Blink: blink_sel = 10 →
  - During blink_phase = 1 (cycles 100–199, 300–399, …): an = 1111 in the idx 2 and 3 slots.
  - Minute digits are unaffected.
  - dp stays high during blink_phase = 1.
- Invalid digit: M2 = 4'd12 → seg = 0111111 in the idx 0 slot.
- Reset mid-scan, then H1 = 0: rst pulsed low during the idx = 2 slot → outputs return to reset values immediately and the scan restarts from idx 3.
  - With LEADING_ZERO_BLANK_EN defined: an = 1111 throughout the idx 3 slot.
  - Without it: an = 0111 with seg = 1000000.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame HH:MM snapshot,
// field blinking and anti-ghost gaps. Optional macro LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module seven_seg_scan #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic [1:0] blink_sel,
    input  logic       dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [HW-1:0] BCNT_LAST = HW'(HALF - 1);

    // Snapshot layout {H1[1:0], H2[3:0], M1[2:0], M2[3:0]}
    localparam int unsigned SNAP_W = 13;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; anything above 9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
        return pat;
    endfunction

    // Pick one digit out of the snapshot and zero-extend it to 4 bits.
    function automatic logic [3:0] digit_sel(input logic [SNAP_W-1:0] snap, input logic [1:0] sel);
        logic [3:0] d;
        case (sel)
            2'd0:    d = snap[3:0];
            2'd1:    d = {1'b0, snap[6:4]};
            2'd2:    d = snap[10:7];
            2'd3:    d = {2'b00, snap[12:11]};
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [3:0] anode_of(input logic [1:0] sel);
        logic [3:0] a;
        case (sel)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    logic [PW-1:0]     pcnt_r, pcnt_s;
    logic [HW-1:0]     bcnt_r, bcnt_s;
    logic              blink_phase_r, blink_phase_s;
    logic [1:0]        idx_r, idx_s;
    logic [SNAP_W-1:0] snap_r, snap_s;
    logic              started_r, started_s;
    logic              tick_s, wrap_s;

    logic [3:0]        an_r, an_s;
    logic [6:0]        seg_r, seg_s;
    logic              dp_r, dp_s;
    logic              frame_r, frame_s;

    logic [3:0]        digit_s;
    logic              blank_s;
    logic              lz_blank_s;

    // State and output registers; reset parks the scan on idx 3 so the first tick shows digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_r        <= '0;
            bcnt_r        <= '0;
            blink_phase_r <= 1'b0;
            idx_r         <= 2'd3;
            snap_r        <= '0;
            started_r     <= 1'b0;
            an_r          <= 4'b1111;
            seg_r         <= 7'b1111111;
            dp_r          <= 1'b1;
            frame_r       <= 1'b0;
        end else begin
            pcnt_r        <= pcnt_s;
            bcnt_r        <= bcnt_s;
            blink_phase_r <= blink_phase_s;
            idx_r         <= idx_s;
            snap_r        <= snap_s;
            started_r     <= started_s;
            an_r          <= an_s;
            seg_r         <= seg_s;
            dp_r          <= dp_s;
            frame_r       <= frame_s;
        end
    end

    // Next-state: prescaler, digit index, blink timebase and once-per-frame snapshot.
    always_comb begin
        tick_s = (pcnt_r == PCNT_LAST);
        wrap_s = tick_s && (idx_r == 2'd3);

        if (tick_s) begin
            pcnt_s = '0;
            idx_s  = idx_r + 2'd1;
        end else begin
            pcnt_s = pcnt_r + PW'(1);
            idx_s  = idx_r;
        end

        if (bcnt_r == BCNT_LAST) begin
            bcnt_s        = '0;
            blink_phase_s = ~blink_phase_r;
        end else begin
            bcnt_s        = bcnt_r + HW'(1);
            blink_phase_s = blink_phase_r;
        end

        // Inputs are sampled only here, so a frame can never mix two different times.
        if (wrap_s) begin
            snap_s    = {H1, H2, M1, M2};
            started_s = 1'b1;
        end else begin
            snap_s    = snap_r;
            started_s = started_r;
        end
    end

    // Output decode: values loaded into the output registers on this edge.
    always_comb begin
        digit_s    = digit_sel(snap_s, idx_s);
        blank_s    = blink_phase_r &&
                     ((!idx_s[1] && blink_sel[0]) || (idx_s[1] && blink_sel[1]));
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_s == 2'd3) && (snap_s[12:11] == 2'd0)) begin
            lz_blank_s = 1'b1;
        end else begin
            lz_blank_s = 1'b0;
        end
`else
        lz_blank_s = 1'b0;
`endif

        // Nothing lights before the first snapshot; every tick gets a one-cycle dark gap.
        if (!started_s) begin
            an_s = 4'b1111;
        end else if (tick_s) begin
            an_s = 4'b1111;
        end else if (blank_s || lz_blank_s) begin
            an_s = 4'b1111;
        end else begin
            an_s = anode_of(idx_s);
        end

        if (started_s) begin
            seg_s = seg_decode(digit_s);
        end else begin
            seg_s = 7'b1111111;
        end

        if (started_s && (idx_s == 2'd2) && dp_en && !blink_phase_r) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end

        frame_s = wrap_s;
    end

    assign an    = an_r;
    assign seg   = seg_r;
    assign dp    = dp_r;
    assign frame = frame_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan with DIV = 10 and HALF = 100.
module tb_seven_seg_scan;

    logic       clk;
    logic       rst;
    logic [1:0] H1;
    logic [3:0] H2;
    logic [2:0] M1;
    logic [3:0] M2;
    logic [1:0] blink_sel;
    logic       dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int tests = 0;
    int fails = 0;
    int e     = 0;   // rising edges since reset release

    seven_seg_scan #(
        .CLK_HZ  (1000),
        .SCAN_HZ (100),
        .BLINK_HZ(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .H1       (H1),
        .H2       (H2),
        .M1       (M1),
        .M2       (M2),
        .blink_sel(blink_sel),
        .dp_en    (dp_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        e = e + 1;
        @(negedge clk);
    endtask

    task automatic advance_to(input int target);
        while (e < target) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; H1 = 2'd1; H2 = 4'd2; M1 = 3'd3; M2 = 4'd4;
        blink_sel = 2'b00; dp_en = 1'b1;
        #23;
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b exp=1111", an); end
        tests++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", dp); end
        tests++; if (frame !== 1'b0) begin fails++; $display("FAIL reset_frame got=%b exp=0", frame); end
        @(negedge clk);
        rst = 1'b1;
        e = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            tests++; if (an !== 4'b1111 || frame !== 1'b0) begin
                fails++; $display("FAIL startup_dark edge=%0d an=%b frame=%b exp an=1111 frame=0", e, an, frame);
            end
        end
        step();
        tests++; if (frame !== 1'b1) begin fails++; $display("FAIL first_frame got=%b exp=1", frame); end
        tests++; if (seg !== 7'b0011001) begin fails++; $display("FAIL first_seg got=%b exp=0011001", seg); end
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL first_gap_an got=%b exp=1111", an); end
        step();
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL first_digit_an got=%b exp=1110", an); end
        tests++; if (frame !== 1'b0) begin fails++; $display("FAIL frame_width got=%b exp=0", frame); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001; exp_dp[0] = 1'b1;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000; exp_dp[1] = 1'b1;
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100; exp_dp[2] = 1'b0;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001; exp_dp[3] = 1'b1;
        advance_to(19);
        tests++; if (an !== exp_an[0] || seg !== exp_seg[0] || dp !== exp_dp[0]) begin
            fails++; $display("FAIL scan_slot0_end an=%b seg=%b dp=%b exp %b %b %b", an, seg, dp, exp_an[0], exp_seg[0], exp_dp[0]);
        end
        for (int k = 1; k <= 3; k++) begin
            advance_to(10 + 10 * k);
            tests++; if (an !== 4'b1111 || seg !== exp_seg[k] || dp !== exp_dp[k]) begin
                fails++; $display("FAIL scan_gap%0d an=%b seg=%b dp=%b exp 1111 %b %b", k, an, seg, dp, exp_seg[k], exp_dp[k]);
            end
            step();
            tests++; if (an !== exp_an[k] || seg !== exp_seg[k] || dp !== exp_dp[k]) begin
                fails++; $display("FAIL scan_slot%0d an=%b seg=%b dp=%b exp %b %b %b", k, an, seg, dp, exp_an[k], exp_seg[k], exp_dp[k]);
            end
        end
    endtask

    task automatic test_coherence();
        advance_to(50);
        tests++; if (frame !== 1'b1 || seg !== 7'b0011001) begin
            fails++; $display("FAIL coh_frame50 frame=%b seg=%b exp 1 0011001", frame, seg);
        end
        advance_to(63);
        H1 = 2'd2; H2 = 4'd3; M1 = 3'd5; M2 = 4'd9;
        advance_to(71);
        tests++; if (an !== 4'b1011 || seg !== 7'b0100100) begin
            fails++; $display("FAIL coh_old_h2 an=%b seg=%b exp 1011 0100100", an, seg);
        end
        advance_to(81);
        tests++; if (an !== 4'b0111 || seg !== 7'b1111001) begin
            fails++; $display("FAIL coh_old_h1 an=%b seg=%b exp 0111 1111001", an, seg);
        end
        advance_to(90);
        tests++; if (frame !== 1'b1 || seg !== 7'b0010000) begin
            fails++; $display("FAIL coh_new_m2 frame=%b seg=%b exp 1 0010000", frame, seg);
        end
        advance_to(100);
        tests++; if (seg !== 7'b0010010) begin fails++; $display("FAIL coh_new_m1 got=%b exp=0010010", seg); end
        advance_to(110);
        tests++; if (seg !== 7'b0110000) begin fails++; $display("FAIL coh_new_h2 got=%b exp=0110000", seg); end
        advance_to(120);
        tests++; if (seg !== 7'b0100100) begin fails++; $display("FAIL coh_new_h1 got=%b exp=0100100", seg); end
    endtask

    task automatic test_blink();
        blink_sel = 2'b10;
        advance_to(121);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL blink_h1_dark got=%b exp=1111", an); end
        advance_to(131);
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL blink_m2_lit got=%b exp=1110", an); end
        advance_to(141);
        tests++; if (an !== 4'b1101) begin fails++; $display("FAIL blink_m1_lit got=%b exp=1101", an); end
        advance_to(150);
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL blink_dp_gap got=%b exp=1", dp); end
        step();
        tests++; if (an !== 4'b1111 || dp !== 1'b1) begin
            fails++; $display("FAIL blink_h2_dark an=%b dp=%b exp 1111 1", an, dp);
        end
        advance_to(191);
        tests++; if (an !== 4'b1111 || seg !== 7'b0110000) begin
            fails++; $display("FAIL blink_h2_dark2 an=%b seg=%b exp 1111 0110000", an, seg);
        end
        advance_to(201);
        tests++; if (an !== 4'b0111 || seg !== 7'b0100100) begin
            fails++; $display("FAIL blink_phase_off an=%b seg=%b exp 0111 0100100", an, seg);
        end
    endtask

    task automatic test_invalid();
        blink_sel = 2'b00;
        M2 = 4'd12;
        advance_to(210);
        tests++; if (frame !== 1'b1 || seg !== 7'b0111111) begin
            fails++; $display("FAIL invalid_dash frame=%b seg=%b exp 1 0111111", frame, seg);
        end
        step();
        tests++; if (an !== 4'b1110) begin fails++; $display("FAIL invalid_an got=%b exp=1110", an); end
    endtask

    task automatic test_reset_mid();
        H1 = 2'd0; H2 = 4'd3; M1 = 3'd5; M2 = 4'd9;
        advance_to(233);
        tests++; if (an !== 4'b1011) begin fails++; $display("FAIL mid_slot_an got=%b exp=1011", an); end
        #2 rst = 1'b0;
        #1;
        tests++; if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame !== 1'b0) begin
            fails++; $display("FAIL async_reset an=%b seg=%b dp=%b frame=%b exp 1111 1111111 1 0", an, seg, dp, frame);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        e = 0;
        advance_to(5);
        tests++; if (an !== 4'b1111) begin fails++; $display("FAIL restart_dark got=%b exp=1111", an); end
        advance_to(10);
        tests++; if (frame !== 1'b1 || seg !== 7'b0010000) begin
            fails++; $display("FAIL restart_frame frame=%b seg=%b exp 1 0010000", frame, seg);
        end
        advance_to(40);
        tests++; if (an !== 4'b1111 || seg !== 7'b1000000) begin
            fails++; $display("FAIL lz_gap an=%b seg=%b exp 1111 1000000", an, seg);
        end
        for (int k = 41; k <= 45; k += 4) begin
            advance_to(k);
`ifdef LEADING_ZERO_BLANK_EN
            tests++; if (an !== 4'b1111) begin fails++; $display("FAIL lz_blank edge=%0d got=%b exp=1111", e, an); end
`else
            tests++; if (an !== 4'b0111 || seg !== 7'b1000000) begin
                fails++; $display("FAIL lz_shown edge=%0d an=%b seg=%b exp 0111 1000000", e, an, seg);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_coherence();
        test_blink();
        test_invalid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
